reg_file_sb: RTL and testbench

- Parametrised successor to the core's single-cycle register file, built for the pipelined rv32i datapath.
- Provides N registered read ports and one write port, with x0 hardwired to zero.
- Adds a per-register busy scoreboard so decode can detect hazards against in-flight writebacks.
- Sits between decode (read and issue) and writeback (write and retire).

---
 rtl/reg_file_pkg.sv | 19 +
 rtl/reg_file_sb_if.sv | 39 +++
 rtl/reg_scoreboard.sv | 53 +++++
 rtl/reg_file_sb.sv | 102 ++++++++++
 tb/tb_reg_file_sb.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_file_pkg
// Shared defaults and types for the pipelined register file with scoreboard.
//   XLEN_DEFAULT      : default data width
//   NUM_REGS_DEFAULT  : default architectural register count
//   ADDR_W_DEFAULT    : register index width derived from NUM_REGS_DEFAULT
//   word_t / reg_idx_t: data word and register index at default sizes
//   REG_ZERO          : index of the hardwired-zero register x0
// ---------------------------------------------------------------------------
package reg_file_pkg;
  localparam int XLEN_DEFAULT     = 32;
  localparam int NUM_REGS_DEFAULT = 32;
  localparam int ADDR_W_DEFAULT   = $clog2(NUM_REGS_DEFAULT);

  typedef logic [XLEN_DEFAULT-1:0]   word_t;
  typedef logic [ADDR_W_DEFAULT-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/reg_file_sb_if.sv
// ---------------------------------------------------------------------------
// reg_file_sb_if
// Decode/writeback bus of the register file.
//   rd_en[p], rd_reg[p]    : per-port read request (decode)
//   rd_data[p], rd_busy[p] : per-port registered read result
//   wr_en, wr_reg, wr_data : writeback port
//   issue_en, issue_reg    : destination marked pending at issue
//   any_busy               : OR of all busy bits
// Modports: master = decode/writeback side, slave = register file.
// ---------------------------------------------------------------------------
interface reg_file_sb_if
  import reg_file_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int NUM_REGS     = NUM_REGS_DEFAULT,
  parameter int NUM_RD_PORTS = 2,
  localparam int ADDR_W      = $clog2(NUM_REGS)
);
  logic [NUM_RD_PORTS-1:0]             rd_en;
  logic [NUM_RD_PORTS-1:0][ADDR_W-1:0] rd_reg;
  logic [NUM_RD_PORTS-1:0][XLEN-1:0]   rd_data;
  logic [NUM_RD_PORTS-1:0]             rd_busy;
  logic                                wr_en;
  logic [ADDR_W-1:0]                   wr_reg;
  logic [XLEN-1:0]                     wr_data;
  logic                                issue_en;
  logic [ADDR_W-1:0]                   issue_reg;
  logic                                any_busy;

  modport master (
    output rd_en, rd_reg, wr_en, wr_reg, wr_data, issue_en, issue_reg,
    input  rd_data, rd_busy, any_busy
  );

  modport slave (
    input  rd_en, rd_reg, wr_en, wr_reg, wr_data, issue_en, issue_reg,
    output rd_data, rd_busy, any_busy
  );
endinterface

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// One busy bit per architectural register. Issue sets a bit, writeback
// clears it; when both hit the same register on one edge the issue wins.
// Bit 0 (x0) is never set.
//   clk, rst      : clock, asynchronous active-high reset
//   i_issue_en/reg: destination being issued
//   i_wr_en/reg   : writeback retiring a destination
//   o_busy        : current busy vector
//   o_busy_next   : busy vector as it will be after this edge
//   o_any_busy    : OR of the current busy vector
// ---------------------------------------------------------------------------
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_issue_en,
  input  logic [ADDR_W-1:0]   i_issue_reg,
  input  logic                i_wr_en,
  input  logic [ADDR_W-1:0]   i_wr_reg,
  output logic [NUM_REGS-1:0] o_busy,
  output logic [NUM_REGS-1:0] o_busy_next,
  output logic                o_any_busy
);
  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_next;

  always_comb begin
    w_busy_next = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (i_issue_en && (i_issue_reg == ADDR_W'(r)))
        w_busy_next[r] = 1'b1;
      else if (i_wr_en && (i_wr_reg == ADDR_W'(r)))
        w_busy_next[r] = 1'b0;
      else
        w_busy_next[r] = r_busy[r];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_next;
  end

  assign o_busy      = r_busy;
  assign o_busy_next = w_busy_next;
  // Drain indication reflects committed state only, not this cycle's update.
  assign o_any_busy  = |r_busy;
endmodule

// File: rtl/reg_file_sb.sv
// ---------------------------------------------------------------------------
// reg_file_sb
// Parametrised register file for the pipelined rv32i datapath: NUM_RD_PORTS
// registered read ports, one write port, x0 hardwired to zero, and a
// per-register busy scoreboard for hazard detection at decode.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset (clears storage, busy, outputs)
//   bus  : reg_file_sb_if.slave (read ports, writeback, issue, any_busy)
// Build option:
//   REG_FILE_BYPASS_EN defined   -> write-first: a read hitting the register
//                                   being written returns the new data and
//                                   the post-edge busy bit.
//   REG_FILE_BYPASS_EN undefined -> read-first: such a read returns the
//                                   pre-write data and pre-write busy bit.
// ---------------------------------------------------------------------------
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int NUM_REGS     = NUM_REGS_DEFAULT,
  parameter int NUM_RD_PORTS = 2,
  localparam int ADDR_W      = $clog2(NUM_REGS)
) (
  input  logic           clk,
  input  logic           rst,
  reg_file_sb_if.slave   bus
);
  localparam logic [ADDR_W-1:0] IDX_ZERO = ADDR_W'(REG_ZERO);

  logic [XLEN-1:0]                   r_regs [NUM_REGS];
  logic [NUM_RD_PORTS-1:0][XLEN-1:0] r_rd_data_p1;
  logic [NUM_RD_PORTS-1:0]           r_rd_busy_p1;

  logic [NUM_REGS-1:0]     w_busy;
  logic [NUM_REGS-1:0]     w_busy_next;
  logic                    w_any_busy;
  logic                    w_wr_ok;
  logic [NUM_RD_PORTS-1:0] w_wr_hit;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .i_issue_en  (bus.issue_en),
    .i_issue_reg (bus.issue_reg),
    .i_wr_en     (bus.wr_en),
    .i_wr_reg    (bus.wr_reg),
    .o_busy      (w_busy),
    .o_busy_next (w_busy_next),
    .o_any_busy  (w_any_busy)
  );

  assign w_wr_ok = bus.wr_en && (bus.wr_reg != IDX_ZERO);

  always_comb begin
    w_wr_hit = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++)
      w_wr_hit[p] = w_wr_ok && (bus.wr_reg == bus.rd_reg[p]);
  end

  // Storage: x0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[bus.wr_reg] <= bus.wr_data;
    end
  end

  // Read stage p0 -> p1: one-cycle registered read, held while rd_en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data_p1 <= '0;
      r_rd_busy_p1 <= '0;
    end else begin
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (bus.rd_en[p]) begin
          if (bus.rd_reg[p] == IDX_ZERO) begin
            r_rd_data_p1[p] <= '0;
            r_rd_busy_p1[p] <= 1'b0;
          end else if (w_wr_hit[p]) begin
`ifdef REG_FILE_BYPASS_EN
            r_rd_data_p1[p] <= bus.wr_data;
            r_rd_busy_p1[p] <= w_busy_next[bus.rd_reg[p]];
`else
            r_rd_data_p1[p] <= r_regs[bus.rd_reg[p]];
            r_rd_busy_p1[p] <= w_busy[bus.rd_reg[p]];
`endif
          end else begin
            r_rd_data_p1[p] <= r_regs[bus.rd_reg[p]];
            r_rd_busy_p1[p] <= w_busy_next[bus.rd_reg[p]];
          end
        end
      end
    end
  end

  assign bus.rd_data  = r_rd_data_p1;
  assign bus.rd_busy  = r_rd_busy_p1;
  assign bus.any_busy = w_any_busy;
endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  import reg_file_pkg::*;

  localparam int NP = 2;
  localparam int NR = NUM_REGS_DEFAULT;
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reg_file_sb_if #(.XLEN(XLEN_DEFAULT), .NUM_REGS(NR), .NUM_RD_PORTS(NP)) bus ();

  reg_file_sb #(.XLEN(XLEN_DEFAULT), .NUM_REGS(NR), .NUM_RD_PORTS(NP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Architectural reference state.
  word_t m_regs [NR];
  bit    m_busy [NR];
  word_t m_rd_data [NP];
  bit    m_rd_busy [NP];

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin m_regs[r] = '0; m_busy[r] = 1'b0; end
    for (int p = 0; p < NP; p++) begin m_rd_data[p] = '0; m_rd_busy[p] = 1'b0; end
  endtask

  task automatic idle();
    bus.rd_en = '0;
    for (int p = 0; p < NP; p++) bus.rd_reg[p] = '0;
    bus.wr_en = 1'b0; bus.wr_reg = '0; bus.wr_data = '0;
    bus.issue_en = 1'b0; bus.issue_reg = '0;
  endtask

  // Advance one clock edge and apply the register-file rules to the model.
  task automatic tick();
    bit nb [NR];
    int wr, rr;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      wr = int'(bus.wr_reg);
      for (int r = 0; r < NR; r++) begin
        if (r == 0) nb[r] = 1'b0;
        else if (bus.issue_en && int'(bus.issue_reg) == r) nb[r] = 1'b1;
        else if (bus.wr_en && wr == r) nb[r] = 1'b0;
        else nb[r] = m_busy[r];
      end
      for (int p = 0; p < NP; p++) begin
        if (bus.rd_en[p]) begin
          rr = int'(bus.rd_reg[p]);
          if (rr == 0) begin
            m_rd_data[p] = '0; m_rd_busy[p] = 1'b0;
          end else if (bus.wr_en && wr == rr) begin
            m_rd_data[p] = BYPASS ? bus.wr_data : m_regs[rr];
            m_rd_busy[p] = BYPASS ? nb[rr] : m_busy[rr];
          end else begin
            m_rd_data[p] = m_regs[rr]; m_rd_busy[p] = nb[rr];
          end
        end
      end
      if (bus.wr_en && wr != 0) m_regs[wr] = bus.wr_data;
      for (int r = 0; r < NR; r++) m_busy[r] = nb[r];
    end
    #1;
  endtask

  task automatic test_reset();
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (bus.rd_data[p] !== '0) begin
        failures++; $display("FAIL reset_rd_data[%0d] got=%h exp=0", p, bus.rd_data[p]);
      end
      checks++;
      if (bus.rd_busy[p] !== 1'b0) begin
        failures++; $display("FAIL reset_rd_busy[%0d] got=%b exp=0", p, bus.rd_busy[p]);
      end
    end
    checks++;
    if (bus.any_busy !== 1'b0) begin
      failures++; $display("FAIL reset_any_busy got=%b exp=0", bus.any_busy);
    end
  endtask

  task automatic test_basic();
    idle(); bus.wr_en = 1'b1; bus.wr_reg = 5'd3; bus.wr_data = 32'h1234_5678;
    tick();
    idle(); bus.rd_en = 2'b11; bus.rd_reg[0] = 5'd3; bus.rd_reg[1] = 5'd3;
    tick();
    idle();
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (bus.rd_data[p] !== 32'h1234_5678) begin
        failures++; $display("FAIL basic_rd_data[%0d] got=%h exp=12345678", p, bus.rd_data[p]);
      end
    end
  endtask

  task automatic test_x0();
    idle(); bus.wr_en = 1'b1; bus.wr_reg = 5'd0; bus.wr_data = 32'hFFFF_FFFF;
    bus.issue_en = 1'b1; bus.issue_reg = 5'd0;
    tick();
    idle(); bus.rd_en = 2'b11;
    tick();
    idle();
    for (int p = 0; p < NP; p++) begin
      checks++;
      if (bus.rd_data[p] !== '0 || bus.rd_busy[p] !== 1'b0) begin
        failures++;
        $display("FAIL x0_read[%0d] got data=%h busy=%b exp data=0 busy=0", p, bus.rd_data[p], bus.rd_busy[p]);
      end
    end
    checks++;
    if (bus.any_busy !== 1'b0) begin
      failures++; $display("FAIL x0_any_busy got=%b exp=0", bus.any_busy);
    end
  endtask

  task automatic test_rw_same();
    word_t exp;
    idle(); bus.wr_en = 1'b1; bus.wr_reg = 5'd7; bus.wr_data = 32'h1;
    tick();
    idle(); bus.wr_en = 1'b1; bus.wr_reg = 5'd7; bus.wr_data = 32'h2;
    bus.rd_en = 2'b01; bus.rd_reg[0] = 5'd7;
    tick();
    idle();
    exp = BYPASS ? 32'h2 : 32'h1;
    checks++;
    if (bus.rd_data[0] !== exp) begin
      failures++; $display("FAIL rw_same_x7 got=%h exp=%h", bus.rd_data[0], exp);
    end
    bus.rd_en = 2'b01; bus.rd_reg[0] = 5'd7;
    tick();
    idle();
    checks++;
    if (bus.rd_data[0] !== 32'h2) begin
      failures++; $display("FAIL rw_after_x7 got=%h exp=2", bus.rd_data[0]);
    end
  endtask

  task automatic test_scoreboard();
    idle(); bus.issue_en = 1'b1; bus.issue_reg = 5'd9;
    bus.rd_en = 2'b01; bus.rd_reg[0] = 5'd9;
    tick();
    idle();
    checks++;
    if (bus.rd_busy[0] !== 1'b1 || bus.any_busy !== 1'b1) begin
      failures++; $display("FAIL sb_issue got busy=%b any=%b exp busy=1 any=1", bus.rd_busy[0], bus.any_busy);
    end
    bus.wr_en = 1'b1; bus.wr_reg = 5'd9; bus.wr_data = 32'hA5;
    tick();
    idle(); bus.rd_en = 2'b10; bus.rd_reg[1] = 5'd9;
    tick();
    idle();
    checks++;
    if (bus.rd_busy[1] !== 1'b0 || bus.any_busy !== 1'b0 || bus.rd_data[1] !== 32'hA5) begin
      failures++;
      $display("FAIL sb_retire got busy=%b any=%b data=%h exp busy=0 any=0 data=a5", bus.rd_busy[1], bus.any_busy, bus.rd_data[1]);
    end
    bus.wr_en = 1'b1; bus.wr_reg = 5'd9; bus.wr_data = 32'h5A;
    bus.issue_en = 1'b1; bus.issue_reg = 5'd9;
    tick();
    idle(); bus.rd_en = 2'b01; bus.rd_reg[0] = 5'd9;
    tick();
    idle();
    checks++;
    if (bus.rd_busy[0] !== 1'b1 || bus.any_busy !== 1'b1 || bus.rd_data[0] !== 32'h5A) begin
      failures++;
      $display("FAIL sb_issue_wins got busy=%b any=%b data=%h exp busy=1 any=1 data=5a", bus.rd_busy[0], bus.any_busy, bus.rd_data[0]);
    end
    bus.wr_en = 1'b1; bus.wr_reg = 5'd9; bus.wr_data = 32'h5B;
    tick();
    idle();
    checks++;
    if (bus.any_busy !== 1'b0) begin
      failures++; $display("FAIL sb_clear_any got=%b exp=0", bus.any_busy);
    end
  endtask

  task automatic test_hold();
    idle(); bus.wr_en = 1'b1; bus.wr_reg = 5'd4; bus.wr_data = 32'h44;
    tick();
    idle(); bus.rd_en = 2'b11; bus.rd_reg[0] = 5'd4; bus.rd_reg[1] = 5'd4;
    tick();
    for (int c = 0; c < 3; c++) begin
      idle(); bus.rd_reg[0] = 5'd4; bus.rd_reg[1] = 5'd4;
      if (c < 2) begin bus.wr_en = 1'b1; bus.wr_reg = 5'd4; bus.wr_data = 32'h100 + 32'(c); end
      if (c > 0) begin bus.issue_en = 1'b1; bus.issue_reg = 5'd4; end
      tick();
      for (int p = 0; p < NP; p++) begin
        checks++;
        if (bus.rd_data[p] !== 32'h44 || bus.rd_busy[p] !== 1'b0) begin
          failures++;
          $display("FAIL hold[%0d] cyc%0d got data=%h busy=%b exp data=44 busy=0", p, c, bus.rd_data[p], bus.rd_busy[p]);
        end
      end
    end
    idle(); bus.rd_en = 2'b01; bus.rd_reg[0] = 5'd4;
    tick();
    idle();
    checks++;
    if (bus.rd_data[0] !== 32'h101 || bus.rd_busy[0] !== 1'b1) begin
      failures++; $display("FAIL hold_release got data=%h busy=%b exp data=101 busy=1", bus.rd_data[0], bus.rd_busy[0]);
    end
  endtask

  task automatic test_async_reset();
    idle(); bus.wr_en = 1'b1; bus.wr_reg = 5'd5; bus.wr_data = 32'hDEAD_BEEF;
    tick();
    idle(); bus.rd_en = 2'b01; bus.rd_reg[0] = 5'd5;
    tick();
    checks++;
    if (bus.rd_data[0] !== 32'hDEAD_BEEF || bus.any_busy !== 1'b1) begin
      failures++; $display("FAIL pre_reset got data=%h any=%b exp data=deadbeef any=1", bus.rd_data[0], bus.any_busy);
    end
    // Same-cycle write and issue are pending when reset lands mid-cycle.
    bus.wr_en = 1'b1; bus.wr_reg = 5'd5; bus.wr_data = 32'h1111;
    bus.issue_en = 1'b1; bus.issue_reg = 5'd6;
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (bus.rd_data[0] !== '0 || bus.any_busy !== 1'b0 || bus.rd_busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got data=%h busy=%b any=%b exp 0 0 0", bus.rd_data[0], bus.rd_busy[0], bus.any_busy);
    end
    tick();
    #2 rst = 1'b0;
    idle(); bus.rd_en = 2'b11; bus.rd_reg[0] = 5'd5; bus.rd_reg[1] = 5'd6;
    tick();
    idle();
    checks++;
    if (bus.rd_data[0] !== 32'h0 || bus.rd_busy[1] !== 1'b0) begin
      failures++; $display("FAIL post_reset_x5 got data=%h busy6=%b exp data=0 busy6=0", bus.rd_data[0], bus.rd_busy[1]);
    end
  endtask

  task automatic test_random();
    bit any;
    for (int n = 0; n < 400; n++) begin
      bus.rd_en = NP'($urandom_range(0, 3));
      for (int p = 0; p < NP; p++) bus.rd_reg[p] = 5'($urandom_range(0, 15));
      bus.wr_en     = ($urandom_range(0, 1) == 1);
      bus.wr_reg    = 5'($urandom_range(0, 15));
      bus.wr_data   = $urandom;
      bus.issue_en  = ($urandom_range(0, 3) == 0);
      bus.issue_reg = 5'($urandom_range(0, 15));
      tick();
      for (int p = 0; p < NP; p++) begin
        checks++;
        if (bus.rd_data[p] !== m_rd_data[p] || bus.rd_busy[p] !== m_rd_busy[p]) begin
          failures++;
          $display("FAIL rand_read[%0d] n=%0d got data=%h busy=%b exp data=%h busy=%b",
                   p, n, bus.rd_data[p], bus.rd_busy[p], m_rd_data[p], m_rd_busy[p]);
        end
      end
      any = 1'b0;
      for (int r = 0; r < NR; r++) any |= m_busy[r];
      checks++;
      if (bus.any_busy !== any) begin
        failures++; $display("FAIL rand_any_busy n=%0d got=%b exp=%b", n, bus.any_busy, any);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_basic();
    test_x0();
    test_rw_same();
    test_scoreboard();
    test_hold();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
